// File: rtl/wshb_arbiter.sv
// ============================================================================
// Module   : wshb_arbiter
// Brief    : Two-master round-robin Wishbone arbiter with an ack quantum that
//            forces hand-over from a master holding cyc permanently.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wshb_arbiter #(
   parameter int QUANTUM = 64,
   parameter int ADR_W   = 32,
   parameter int DAT_W   = 16,
   localparam int SEL_W  = DAT_W / 8
) (
   input  logic             clk,
   input  logic             rst,
   // master 0
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic [DAT_W-1:0] m0_dat_ms_i,
   input  logic [2:0]       m0_cti_i,
   input  logic [1:0]       m0_bte_i,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   output logic [DAT_W-1:0] m0_dat_sm_o,
   // master 1
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic [DAT_W-1:0] m1_dat_ms_i,
   input  logic [2:0]       m1_cti_i,
   input  logic [1:0]       m1_bte_i,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic [DAT_W-1:0] m1_dat_sm_o,
   // slave (SDRAM controller)
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic [DAT_W-1:0] s_dat_ms_o,
   output logic [2:0]       s_cti_o,
   output logic [1:0]       s_bte_o,
   input  logic             s_ack_i,
   input  logic             s_err_i,
   input  logic [DAT_W-1:0] s_dat_sm_i,
   output logic [1:0]       grant_o
);

   localparam int CNT_W = $clog2(QUANTUM + 1);
   localparam logic [CNT_W-1:0] C_QUANT    = CNT_W'(QUANTUM);
   localparam logic [CNT_W-1:0] C_QUANT_M1 = CNT_W'(QUANTUM - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic term;
   logic quantum_hit;

   assign term        = s_ack_i | s_err_i;
   // Counts the termination of the current cycle too, so hand-over lands on it.
   assign quantum_hit = (cnt_q == C_QUANT) || ((cnt_q == C_QUANT_M1) && term);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
               state_d = S_OWN0;
               cnt_d   = '0;
               last_d  = 1'b0;
            end else if (m1_cyc_i) begin
               state_d = S_OWN1;
               cnt_d   = '0;
               last_d  = 1'b1;
            end
         end
         S_OWN0: begin
            if (term && (cnt_q != C_QUANT)) cnt_d = cnt_q + 1'b1;
            if (!m0_cyc_i) begin
               state_d = m1_cyc_i ? S_OWN1 : S_IDLE;
               if (m1_cyc_i) begin
                  cnt_d  = '0;
                  last_d = 1'b1;
               end
            end else if (quantum_hit && m1_cyc_i && term) begin
               state_d = S_OWN1;
               cnt_d   = '0;
               last_d  = 1'b1;
            end
         end
         S_OWN1: begin
            if (term && (cnt_q != C_QUANT)) cnt_d = cnt_q + 1'b1;
            if (!m1_cyc_i) begin
               state_d = m0_cyc_i ? S_OWN0 : S_IDLE;
               if (m0_cyc_i) begin
                  cnt_d  = '0;
                  last_d = 1'b0;
               end
            end else if (quantum_hit && m0_cyc_i && term) begin
               state_d = S_OWN0;
               cnt_d   = '0;
               last_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   logic own0, own1;
   assign own0 = (state_q == S_OWN0);
   assign own1 = (state_q == S_OWN1);

   // Handshake lines are gated by rst so a transfer in flight is dropped at once.
   assign s_cyc_o = !rst && ((own0 && m0_cyc_i) || (own1 && m1_cyc_i));
   assign s_stb_o = !rst && ((own0 && m0_stb_i) || (own1 && m1_stb_i));

   assign s_we_o     = own1 ? m1_we_i     : m0_we_i;
   assign s_adr_o    = own1 ? m1_adr_i    : m0_adr_i;
   assign s_sel_o    = own1 ? m1_sel_i    : m0_sel_i;
   assign s_dat_ms_o = own1 ? m1_dat_ms_i : m0_dat_ms_i;
   assign s_cti_o    = own1 ? m1_cti_i    : m0_cti_i;
   assign s_bte_o    = own1 ? m1_bte_i    : m0_bte_i;

   assign m0_ack_o = !rst && own0 && s_ack_i;
   assign m0_err_o = !rst && own0 && s_err_i;
   assign m1_ack_o = !rst && own1 && s_ack_i;
   assign m1_err_o = !rst && own1 && s_err_i;

   assign m0_dat_sm_o = s_dat_sm_i;
   assign m1_dat_sm_o = s_dat_sm_i;

   assign grant_o = {own1, own0};

endmodule

`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
// ============================================================================
// Module   : tb_wshb_arbiter
// Brief    : Directed vector table plus corner sequences for wshb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wshb_arbiter;

   localparam int ADR_W = 32;
   localparam int DAT_W = 16;
   localparam int SEL_W = DAT_W / 8;
   localparam logic [ADR_W-1:0] C_ADR0 = 32'h0000_0A00;
   localparam logic [ADR_W-1:0] C_ADR1 = 32'h0000_0B00;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             c0, s0, c1, s1;
   logic             auto_ack, man_ack, man_err;
   logic [DAT_W-1:0] sdat;

   // DUT A: QUANTUM=4
   logic             a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
   logic [DAT_W-1:0] a_m0_dat, a_m1_dat, a_s_dat_ms;
   logic             a_s_cyc, a_s_stb, a_s_we, a_s_ack;
   logic [ADR_W-1:0] a_s_adr;
   logic [SEL_W-1:0] a_s_sel;
   logic [2:0]       a_s_cti;
   logic [1:0]       a_s_bte, a_grant;
   // DUT B: QUANTUM=64
   logic             b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
   logic [DAT_W-1:0] b_m0_dat, b_m1_dat, b_s_dat_ms;
   logic             b_s_cyc, b_s_stb, b_s_we, b_s_ack;
   logic [ADR_W-1:0] b_s_adr;
   logic [SEL_W-1:0] b_s_sel;
   logic [2:0]       b_s_cti;
   logic [1:0]       b_s_bte, b_grant;

   // Zero-wait slave: acks every strobe it sees when auto_ack is set.
   assign a_s_ack = auto_ack ? a_s_stb : man_ack;
   assign b_s_ack = auto_ack ? b_s_stb : man_ack;

   wshb_arbiter #(.QUANTUM(4), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut_a (
      .clk(clk), .rst(rst),
      .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(1'b0), .m0_adr_i(C_ADR0),
      .m0_sel_i(2'b11), .m0_dat_ms_i(16'h0000), .m0_cti_i(3'b000), .m0_bte_i(2'b00),
      .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_dat_sm_o(a_m0_dat),
      .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(1'b1), .m1_adr_i(C_ADR1),
      .m1_sel_i(2'b01), .m1_dat_ms_i(16'h5A5A), .m1_cti_i(3'b010), .m1_bte_i(2'b01),
      .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_dat_sm_o(a_m1_dat),
      .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
      .s_sel_o(a_s_sel), .s_dat_ms_o(a_s_dat_ms), .s_cti_o(a_s_cti), .s_bte_o(a_s_bte),
      .s_ack_i(a_s_ack), .s_err_i(man_err), .s_dat_sm_i(sdat), .grant_o(a_grant)
   );

   wshb_arbiter #(.QUANTUM(64), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut_b (
      .clk(clk), .rst(rst),
      .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(1'b0), .m0_adr_i(C_ADR0),
      .m0_sel_i(2'b11), .m0_dat_ms_i(16'h0000), .m0_cti_i(3'b000), .m0_bte_i(2'b00),
      .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_dat_sm_o(b_m0_dat),
      .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(1'b1), .m1_adr_i(C_ADR1),
      .m1_sel_i(2'b01), .m1_dat_ms_i(16'h5A5A), .m1_cti_i(3'b010), .m1_bte_i(2'b01),
      .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_dat_sm_o(b_m1_dat),
      .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
      .s_sel_o(b_s_sel), .s_dat_ms_o(b_s_dat_ms), .s_cti_o(b_s_cti), .s_bte_o(b_s_bte),
      .s_ack_i(b_s_ack), .s_err_i(man_err), .s_dat_sm_i(sdat), .grant_o(b_grant)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic a0, input logic b0,
                        input logic a1, input logic b1);
      rst = r; c0 = a0; s0 = b0; c1 = a1; s1 = b1;
   endtask

   typedef struct packed {
      logic       rst;
      logic       c0, s0, c1, s1;
      logic       ack, err;
      logic       exp_stb;
      logic [3:0] exp_ae;    // {m1_err, m0_err, m1_ack, m0_ack}
      logic [1:0] exp_g;     // grant after the edge
   } vec_t;

   vec_t vecs [0:17];

   int n0, n1, nacc;
   logic [1:0] g_exp;

   initial begin
      // rst c0 s0 c1 s1 ack err | stb ae g
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b01};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 2'b01};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 2'b01};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 2'b01};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 2'b10};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'b10};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b01};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b10};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 2'b10};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b10};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b10};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b10};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b10};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'b10};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b01};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00};

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      auto_ack = 1'b0; man_ack = 1'b0; man_err = 1'b0; sdat = 16'hC3E1;
      tick();

      // Table: combinational outputs in the current state, then grant after the edge
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].rst, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1);
         man_ack = vecs[i].ack;
         man_err = vecs[i].err;
         #1;
         chk($sformatf("vec%0d_stb", i), {31'd0, a_s_stb}, {31'd0, vecs[i].exp_stb});
         chk($sformatf("vec%0d_ackerr", i), {28'd0, a_m1_err, a_m0_err, a_m1_ack, a_m0_ack},
             {28'd0, vecs[i].exp_ae});
         tick();
         chk($sformatf("vec%0d_grant", i), {30'd0, a_grant}, {30'd0, vecs[i].exp_g});
      end
      man_ack = 1'b0; man_err = 1'b0;

      // m0 alone, 200 acks, m1 never acked (QUANTUM=64)
      auto_ack = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("m0_only_grant", {30'd0, b_grant}, 32'd1);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 200; i++) begin
         n0 += int'(b_m0_ack);
         n1 += int'(b_m1_ack);
         tick();
      end
      chk("m0_only_acks", n0, 200);
      chk("m0_only_m1acks", n1, 0);

      // m1 joins at ack #10: hand-over right after m0's 64th ack
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      n0 = 0;
      for (int i = 0; i < 300; i++) begin
         if (b_m0_ack) begin
            n0++;
            if (n0 == 10) begin c1 = 1'b1; s1 = 1'b1; end
         end
         tick();
         if (b_grant == 2'b10) break;
      end
      chk("q64_grant_switch", {30'd0, b_grant}, 32'd2);
      chk("q64_m0_acks", n0, 64);
      for (int i = 0; i < 3; i++) begin
         chk("q64_m0_ack_blocked", {31'd0, b_m0_ack}, 32'd0);
         chk("q64_m1_ack", {31'd0, b_m1_ack}, 32'd1);
         tick();
      end

      // Both continuous, QUANTUM=4: alternating grant, no lost/duplicated acks
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      n0 = 0; n1 = 0; nacc = 0;
      for (int i = 0; i < 32; i++) begin
         g_exp = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
         chk($sformatf("rr_grant%0d", i), {30'd0, a_grant}, {30'd0, g_exp});
         n0 += int'(a_m0_ack);
         n1 += int'(a_m1_ack);
         nacc += int'(a_s_stb & a_s_ack);
         tick();
      end
      chk("rr_total_acks", n0 + n1, nacc);
      chk("rr_m0_acks", n0, 16);
      chk("rr_m1_acks", n1, 16);
      chk("rr_dat_bcast", {16'd0, a_m1_dat}, {16'd0, sdat});

      // m1 owner drops cyc after 3 acks with m0 waiting
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      chk("drop_m1_grant", {30'd0, a_grant}, 32'd2);
      c0 = 1'b1; s0 = 1'b1;
      n1 = 0;
      repeat (3) begin
         n1 += int'(a_m1_ack);
         tick();
      end
      chk("drop_m1_acks", n1, 3);
      chk("drop_m1_hold", {30'd0, a_grant}, 32'd2);
      c1 = 1'b0; s1 = 1'b0;
      tick();
      chk("drop_grant_m0", {30'd0, a_grant}, 32'd1);
      chk("drop_adr_m0", a_s_adr, C_ADR0);
      c1 = 1'b1; s1 = 1'b1;
      n0 = 0;
      for (int i = 0; i < 20; i++) begin
         n0 += int'(a_m0_ack);
         tick();
         if (a_grant == 2'b10) break;
      end
      chk("drop_cnt_restart", n0, 4);

      // Simultaneous requests follow last: m0 after reset, then m1
      auto_ack = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      chk("sim_first_m0", {30'd0, a_grant}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("sim_idle", {30'd0, a_grant}, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk("sim_second_m1", {30'd0, a_grant}, 32'd2);

      // Reset mid-burst with stb pending under slave wait states
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      chk("rstmid_grant_m1", {30'd0, a_grant}, 32'd2);
      tick();
      chk("rstmid_stb_pend", {31'd0, a_s_stb}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_stb_forced", {31'd0, a_s_stb}, 32'd0);
      chk("rstmid_cyc_forced", {31'd0, a_s_cyc}, 32'd0);
      tick();
      chk("rstmid_grant_idle", {30'd0, a_grant}, 32'd0);
      c0 = 1'b1; s0 = 1'b1;
      rst = 1'b0;
      tick();
      chk("rstmid_m0_first", {30'd0, a_grant}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
